pipelined_control_unit: RTL and testbench
=========================================

Name: pipelined_control_unit

Overview:
- Successor to the single-cycle opcode decoder: decodes the RV32I opcode in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Adds JALR decode, load-use hazard detection with bubble insertion, and branch/jump flush.
- Sits beside the datapath pipeline registers. The datapath reads stage-aligned control from this block instead of staging it itself.

Parameters:
ALU_OP_WIDTH, 3, width of ALU operation code; must be >=3; codes zero-extended.
REG_ADDR_WIDTH, 5, register-index width used in hazard compares.
CNT_WIDTH, 16, width of performance counters (only with optional feature).

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous active-high reset
OP_ID_i  input  7  opcode of instruction in ID
Rd_ID_i  input  REG_ADDR_WIDTH  destination register of ID instruction
Rs1_ID_i  input  REG_ADDR_WIDTH  source 1 of ID instruction
Rs2_ID_i  input  REG_ADDR_WIDTH  source 2 of ID instruction
Redirect_EX_i  input  1  datapath: taken branch, JAL or JALR resolved in EX
Stall_o  output  1  hold PC and IF/ID (combinational)
Flush_IF_ID_o  output  1  kill IF/ID contents (combinational, equals Redirect_EX_i)
ALU_Op_EX_o  output  ALU_OP_WIDTH  ALU operation for EX
ALU_Src_EX_o  output  1  immediate operand select for EX
Branch_EX_o  output  1  conditional branch in EX
Jal_EX_o  output  1  JAL in EX
Jalr_EX_o  output  1  JALR in EX
Mem_Read_MEM_o  output  1  load in MEM
Mem_Write_MEM_o  output  1  store in MEM
Rd_MEM_o  output  REG_ADDR_WIDTH  destination in MEM
Reg_Write_WB_o  output  1  register write in WB
Mem_to_Reg_WB_o  output  1  writeback from memory
Jal_WB_o  output  1  writeback PC+4 (JAL or JALR)
Rd_WB_o  output  REG_ADDR_WIDTH  destination in WB

Behaviour:
- Decode is combinational on OP_ID_i. Fields are {Jal,Jalr,Branch,MemToReg,RegWrite,MemRead,MemWrite,ALUSrc,ALUOp}:
  - R 0110011: RegW, op 000
  - I-logic 0010011: RegW, ALUSrc, op 001
  - LUI 0110111: RegW, ALUSrc, op 010
  - B 1100011: Branch, op 011
  - S 0100011: MemW, ALUSrc, op 100
  - Load 0000011: MemToReg, RegW, MemRd, ALUSrc, op 101
  - JAL 1101111: Jal, RegW, ALUSrc, op 110
  - JALR 1100111: Jalr, RegW, ALUSrc, op 111
  - Any other opcode: all zero (bubble).
- Bubble means all control bits 0 and Rd 0. Only bubbles are stored; no valid bit is needed.
- Reset (async): every stage register is a bubble. All registered outputs are 0.
- Each clock: ID/EX <= decode (or bubble); EX/MEM <= ID/EX subset; MEM/WB <= EX/MEM subset. EX/MEM and MEM/WB always advance. Latency from ID to WB is 3 cycles.
- Load-use: Stall_o = EX.MemRead & EX.Rd!=0 & (EX.Rd==Rs1_ID_i | EX.Rd==Rs2_ID_i).
  - Compare is suppressed when OP_ID_i is LUI or JAL.
  - On stall, ID/EX loads a bubble; the ID instruction re-presents next cycle, and Stall_o then deasserts.
- Redirect_EX_i: Flush_IF_ID_o=1 and ID/EX loads a bubble. The EX instruction itself advances normally.
- Redirect and stall in the same cycle: flush wins and Stall_o is forced 0.
- Rd 0 with RegW: propagated unchanged. The register file ignores x0.

Optional Feature:
CTRL_PERF_CNT_EN:
- Defined: adds output ports Stall_Cnt_o and Flush_Cnt_o, each CNT_WIDTH bits. They count cycles with Stall_o=1 and Flush_IF_ID_o=1 respectively, saturate at all-ones, and reset to 0.
- Undefined: ports and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams
  - ALU-op code constants
  - control-bundle field index constants
  - stage-bundle widths
- Natural sub-module: hazard_detect_unit (combinational load-use compare and flush priority), instantiated once.

Test Plan:
- Reset asserted mid-stream with a load in EX -> all outputs 0 immediately; Stall_o=0.
- R-type add (OP 0110011, rd=5) -> ALU_Op_EX_o=000 next cycle; Reg_Write_WB_o=1 and Rd_WB_o=5 three cycles after ID.
- lw x6 then add x7,x6,x1 back-to-back -> Stall_o=1 for exactly 1 cycle; bubble in EX (all zeros); add reaches EX one cycle later.
- lw x0 followed by a user of x0 -> Stall_o stays 0.
- beq in EX with Redirect_EX_i=1 while a load-use pair is in ID/EX -> Flush_IF_ID_o=1, Stall_o=0, ID/EX bubble.
- JALR (1100111, rd=1) -> Jalr_EX_o=1, ALU_Op_EX_o=111; Jal_WB_o=1 and Rd_WB_o=1 in WB.
- Undefined opcode 1111111 -> all stage controls stay 0.
- With CTRL_PERF_CNT_EN: 3 stalls and 2 flushes -> Stall_Cnt_o=3, Flush_Cnt_o=2.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, ALU codes, control-bundle layout and ID decode for pipelined_control_unit
// Contents:
//   OPC_*          RV32I major opcodes recognised by decode
//   ALU_*          3-bit ALU operation codes (zero-extended by the top)
//   F_*            bit positions inside the ID/EX flag vector
//   M_*, W_*       bit positions inside the EX/MEM and MEM/WB control vectors
//   decode_opcode  combinational opcode -> control bundle (unknown opcode -> bubble)
package ctrl_pkg;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LUI  = 7'b0110111;
    localparam logic [6:0] OPC_B    = 7'b1100011;
    localparam logic [6:0] OPC_S    = 7'b0100011;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    localparam int ALU_CODE_W = 3;
    localparam logic [ALU_CODE_W-1:0] ALU_R    = 3'b000;
    localparam logic [ALU_CODE_W-1:0] ALU_I    = 3'b001;
    localparam logic [ALU_CODE_W-1:0] ALU_LUI  = 3'b010;
    localparam logic [ALU_CODE_W-1:0] ALU_B    = 3'b011;
    localparam logic [ALU_CODE_W-1:0] ALU_S    = 3'b100;
    localparam logic [ALU_CODE_W-1:0] ALU_LOAD = 3'b101;
    localparam logic [ALU_CODE_W-1:0] ALU_JAL  = 3'b110;
    localparam logic [ALU_CODE_W-1:0] ALU_JALR = 3'b111;

    // ID/EX flag vector
    localparam int F_ALUSRC   = 0;
    localparam int F_MEMW     = 1;
    localparam int F_MEMRD    = 2;
    localparam int F_REGW     = 3;
    localparam int F_MEMTOREG = 4;
    localparam int F_BRANCH   = 5;
    localparam int F_JALR     = 6;
    localparam int F_JAL      = 7;
    localparam int CTRL_FLAGS_W = 8;

    // EX/MEM control vector; JAL and JALR collapse into one link bit here
    localparam int M_MEMRD    = 0;
    localparam int M_MEMWR    = 1;
    localparam int M_REGW     = 2;
    localparam int M_MEMTOREG = 3;
    localparam int M_LINK     = 4;
    localparam int MEM_CTRL_W = 5;

    // MEM/WB control vector
    localparam int W_REGW     = 0;
    localparam int W_MEMTOREG = 1;
    localparam int W_LINK     = 2;
    localparam int WB_CTRL_W  = 3;

    typedef struct packed {
        logic [CTRL_FLAGS_W-1:0] flags;
        logic [ALU_CODE_W-1:0]   alu;
    } ctrl_t;

    function automatic ctrl_t decode_opcode(input logic [6:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OPC_R: begin
                c.flags[F_REGW] = 1'b1;
                c.alu = ALU_R;
            end
            OPC_I: begin
                c.flags[F_REGW]   = 1'b1;
                c.flags[F_ALUSRC] = 1'b1;
                c.alu = ALU_I;
            end
            OPC_LUI: begin
                c.flags[F_REGW]   = 1'b1;
                c.flags[F_ALUSRC] = 1'b1;
                c.alu = ALU_LUI;
            end
            OPC_B: begin
                c.flags[F_BRANCH] = 1'b1;
                c.alu = ALU_B;
            end
            OPC_S: begin
                c.flags[F_MEMW]   = 1'b1;
                c.flags[F_ALUSRC] = 1'b1;
                c.alu = ALU_S;
            end
            OPC_LOAD: begin
                c.flags[F_MEMTOREG] = 1'b1;
                c.flags[F_REGW]     = 1'b1;
                c.flags[F_MEMRD]    = 1'b1;
                c.flags[F_ALUSRC]   = 1'b1;
                c.alu = ALU_LOAD;
            end
            OPC_JAL: begin
                c.flags[F_JAL]    = 1'b1;
                c.flags[F_REGW]   = 1'b1;
                c.flags[F_ALUSRC] = 1'b1;
                c.alu = ALU_JAL;
            end
            OPC_JALR: begin
                c.flags[F_JALR]   = 1'b1;
                c.flags[F_REGW]   = 1'b1;
                c.flags[F_ALUSRC] = 1'b1;
                c.alu = ALU_JALR;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hazard_detect_unit.sv
// rtl/hazard_detect_unit.sv - load-use stall detection and redirect flush priority
// Ports:
//   ex_mem_read   load currently in EX
//   ex_rd         destination of the EX instruction
//   rs1_id/rs2_id sources of the ID instruction
//   op_id         opcode of the ID instruction
//   redirect_ex   taken branch / jump resolved in EX
//   stall         hold PC and IF/ID, bubble into ID/EX
//   flush         kill IF/ID, bubble into ID/EX
module hazard_detect_unit
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      ex_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_id,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_id,
    input  logic [6:0]                op_id,
    input  logic                      redirect_ex,
    output logic                      stall,
    output logic                      flush
);

    logic uses_rs;
    logic load_use;

    always_comb begin
        // LUI and JAL carry immediate bits in the rs fields, so matches there are false
        uses_rs  = !((op_id == OPC_LUI) || (op_id == OPC_JAL));
        load_use = ex_mem_read && (ex_rd != '0) &&
                   ((ex_rd == rs1_id) || (ex_rd == rs2_id));
        flush    = redirect_ex;
        // the ID instruction is being killed anyway, so holding it would be wrong
        stall    = load_use && uses_rs && !redirect_ex;
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - RV32I control decode staged through ID/EX, EX/MEM, MEM/WB
// Optional feature macro: CTRL_PERF_CNT_EN (adds Stall_Cnt_o / Flush_Cnt_o saturating counters)
// Ports:
//   clk, reset                      rising-edge clock, async active-high reset
//   OP_ID_i, Rd/Rs1/Rs2_ID_i        instruction fields in ID
//   Redirect_EX_i                   taken branch / JAL / JALR resolved in EX
//   Stall_o, Flush_IF_ID_o          combinational hazard controls
//   *_EX_o, *_MEM_o, *_WB_o         stage-aligned control for the datapath
//   Stall_Cnt_o, Flush_Cnt_o        cycle counters (only with CTRL_PERF_CNT_EN)
module pipelined_control_unit
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_WIDTH   = 3,
    parameter int REG_ADDR_WIDTH = 5
`ifdef CTRL_PERF_CNT_EN
    ,
    parameter int CNT_WIDTH      = 16
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [6:0]                OP_ID_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rd_ID_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1_ID_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2_ID_i,
    input  logic                      Redirect_EX_i,
    output logic                      Stall_o,
    output logic                      Flush_IF_ID_o,
    output logic [ALU_OP_WIDTH-1:0]   ALU_Op_EX_o,
    output logic                      ALU_Src_EX_o,
    output logic                      Branch_EX_o,
    output logic                      Jal_EX_o,
    output logic                      Jalr_EX_o,
    output logic                      Mem_Read_MEM_o,
    output logic                      Mem_Write_MEM_o,
    output logic [REG_ADDR_WIDTH-1:0] Rd_MEM_o,
    output logic                      Reg_Write_WB_o,
    output logic                      Mem_to_Reg_WB_o,
    output logic                      Jal_WB_o,
    output logic [REG_ADDR_WIDTH-1:0] Rd_WB_o
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]      Stall_Cnt_o,
    output logic [CNT_WIDTH-1:0]      Flush_Cnt_o
`endif
);

    ctrl_t id_dec;
    logic  stall;
    logic  flush;
    logic  kill_id;

    logic [CTRL_FLAGS_W-1:0]   ex_flags_q, ex_flags_d;
    logic [ALU_OP_WIDTH-1:0]   ex_alu_q, ex_alu_d;
    logic [REG_ADDR_WIDTH-1:0] ex_rd_q, ex_rd_d;
    logic [MEM_CTRL_W-1:0]     mem_ctrl_q, mem_ctrl_d;
    logic [REG_ADDR_WIDTH-1:0] mem_rd_q, mem_rd_d;
    logic [WB_CTRL_W-1:0]      wb_ctrl_q, wb_ctrl_d;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;

    hazard_detect_unit #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_hazard (
        .ex_mem_read (ex_flags_q[F_MEMRD]),
        .ex_rd       (ex_rd_q),
        .rs1_id      (Rs1_ID_i),
        .rs2_id      (Rs2_ID_i),
        .op_id       (OP_ID_i),
        .redirect_ex (Redirect_EX_i),
        .stall       (stall),
        .flush       (flush)
    );

    always_comb begin
        id_dec  = decode_opcode(OP_ID_i);
        kill_id = stall || flush;

        ex_flags_d = kill_id ? '0 : id_dec.flags;
        ex_alu_d   = kill_id ? '0 : ALU_OP_WIDTH'(id_dec.alu);
        // unknown opcodes decode to an all-zero bundle; keep Rd zero too so they are true bubbles
        ex_rd_d    = (kill_id || (id_dec == '0)) ? '0 : Rd_ID_i;

        mem_ctrl_d             = '0;
        mem_ctrl_d[M_MEMRD]    = ex_flags_q[F_MEMRD];
        mem_ctrl_d[M_MEMWR]    = ex_flags_q[F_MEMW];
        mem_ctrl_d[M_REGW]     = ex_flags_q[F_REGW];
        mem_ctrl_d[M_MEMTOREG] = ex_flags_q[F_MEMTOREG];
        mem_ctrl_d[M_LINK]     = ex_flags_q[F_JAL] || ex_flags_q[F_JALR];
        mem_rd_d               = ex_rd_q;

        wb_ctrl_d             = '0;
        wb_ctrl_d[W_REGW]     = mem_ctrl_q[M_REGW];
        wb_ctrl_d[W_MEMTOREG] = mem_ctrl_q[M_MEMTOREG];
        wb_ctrl_d[W_LINK]     = mem_ctrl_q[M_LINK];
        wb_rd_d               = mem_rd_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_flags_q <= '0;
            ex_alu_q   <= '0;
            ex_rd_q    <= '0;
            mem_ctrl_q <= '0;
            mem_rd_q   <= '0;
            wb_ctrl_q  <= '0;
            wb_rd_q    <= '0;
        end else begin
            ex_flags_q <= ex_flags_d;
            ex_alu_q   <= ex_alu_d;
            ex_rd_q    <= ex_rd_d;
            mem_ctrl_q <= mem_ctrl_d;
            mem_rd_q   <= mem_rd_d;
            wb_ctrl_q  <= wb_ctrl_d;
            wb_rd_q    <= wb_rd_d;
        end
    end

    assign Stall_o         = stall;
    assign Flush_IF_ID_o   = flush;
    assign ALU_Op_EX_o     = ex_alu_q;
    assign ALU_Src_EX_o    = ex_flags_q[F_ALUSRC];
    assign Branch_EX_o     = ex_flags_q[F_BRANCH];
    assign Jal_EX_o        = ex_flags_q[F_JAL];
    assign Jalr_EX_o       = ex_flags_q[F_JALR];
    assign Mem_Read_MEM_o  = mem_ctrl_q[M_MEMRD];
    assign Mem_Write_MEM_o = mem_ctrl_q[M_MEMWR];
    assign Rd_MEM_o        = mem_rd_q;
    assign Reg_Write_WB_o  = wb_ctrl_q[W_REGW];
    assign Mem_to_Reg_WB_o = wb_ctrl_q[W_MEMTOREG];
    assign Jal_WB_o        = wb_ctrl_q[W_LINK];
    assign Rd_WB_o         = wb_rd_q;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign Stall_Cnt_o = stall_cnt_q;
    assign Flush_Cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - self-checking bench for pipelined_control_unit
module tb_pipelined_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op_id;
    logic [4:0] rd_id, rs1_id, rs2_id;
    logic       redir;

    logic       Stall_o, Flush_IF_ID_o;
    logic [2:0] ALU_Op_EX_o;
    logic       ALU_Src_EX_o, Branch_EX_o, Jal_EX_o, Jalr_EX_o;
    logic       Mem_Read_MEM_o, Mem_Write_MEM_o;
    logic [4:0] Rd_MEM_o;
    logic       Reg_Write_WB_o, Mem_to_Reg_WB_o, Jal_WB_o;
    logic [4:0] Rd_WB_o;
`ifdef CTRL_PERF_CNT_EN
    logic [15:0] Stall_Cnt_o, Flush_Cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipelined_control_unit dut (
        .clk             (clk),
        .reset           (reset),
        .OP_ID_i         (op_id),
        .Rd_ID_i         (rd_id),
        .Rs1_ID_i        (rs1_id),
        .Rs2_ID_i        (rs2_id),
        .Redirect_EX_i   (redir),
        .Stall_o         (Stall_o),
        .Flush_IF_ID_o   (Flush_IF_ID_o),
        .ALU_Op_EX_o     (ALU_Op_EX_o),
        .ALU_Src_EX_o    (ALU_Src_EX_o),
        .Branch_EX_o     (Branch_EX_o),
        .Jal_EX_o        (Jal_EX_o),
        .Jalr_EX_o       (Jalr_EX_o),
        .Mem_Read_MEM_o  (Mem_Read_MEM_o),
        .Mem_Write_MEM_o (Mem_Write_MEM_o),
        .Rd_MEM_o        (Rd_MEM_o),
        .Reg_Write_WB_o  (Reg_Write_WB_o),
        .Mem_to_Reg_WB_o (Mem_to_Reg_WB_o),
        .Jal_WB_o        (Jal_WB_o),
        .Rd_WB_o         (Rd_WB_o)
`ifdef CTRL_PERF_CNT_EN
        ,
        .Stall_Cnt_o     (Stall_Cnt_o),
        .Flush_Cnt_o     (Flush_Cnt_o)
`endif
    );

    logic [21:0] all_regs;
    assign all_regs = {ALU_Op_EX_o, ALU_Src_EX_o, Branch_EX_o, Jal_EX_o, Jalr_EX_o,
                       Mem_Read_MEM_o, Mem_Write_MEM_o, Rd_MEM_o,
                       Reg_Write_WB_o, Mem_to_Reg_WB_o, Jal_WB_o, Rd_WB_o};

    // opcode table ordered by ALU code: an instruction's ALU code is its row index
    logic [6:0] tbl [8];
    localparam logic [6:0] R_OP = 7'b0110011, B_OP = 7'b1100011, LD_OP = 7'b0000011;
    localparam logic [6:0] LUI_OP = 7'b0110111, JAL_OP = 7'b1101111, JALR_OP = 7'b1100111;
    localparam logic [6:0] UNDEF_OP = 7'b1111111;

    typedef struct {
        logic [6:0] op;
        logic [4:0] rd;
    } slot_t;

    function automatic int code_of(input logic [6:0] op);
        for (int i = 0; i < 8; i++) begin
            if (tbl[i] == op) return i;
        end
        return -1;
    endfunction

    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] s1,
                         input logic [4:0] s2, input logic rdr);
        op_id = op; rd_id = rd; rs1_id = s1; rs2_id = s2; redir = rdr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(7'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        #2;
        total++;
        if (all_regs !== 22'd0) begin bad++; $display("FAIL reset_regs got=%h exp=0", all_regs); end
        total++;
        if ({Stall_o, Flush_IF_ID_o} !== 2'b00) begin bad++; $display("FAIL reset_hz got=%b exp=00", {Stall_o, Flush_IF_ID_o}); end
        @(posedge clk); #1;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_rtype();
        drive(R_OP, 5'd5, 5'd1, 5'd2, 1'b0);
        tick();
        drive(7'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        total++;
        if ({ALU_Op_EX_o, ALU_Src_EX_o} !== 4'b0000) begin bad++; $display("FAIL rtype_ex got=%b exp=0000", {ALU_Op_EX_o, ALU_Src_EX_o}); end
        tick();
        tick();
        total++;
        if ({Reg_Write_WB_o, Mem_to_Reg_WB_o, Jal_WB_o, Rd_WB_o} !== {3'b100, 5'd5}) begin
            bad++; $display("FAIL rtype_wb got=%b_%0d exp=100_5", {Reg_Write_WB_o, Mem_to_Reg_WB_o, Jal_WB_o}, Rd_WB_o);
        end
    endtask

    task automatic test_load_use();
        drive(LD_OP, 5'd6, 5'd2, 5'd0, 1'b0);
        tick();
        drive(R_OP, 5'd7, 5'd6, 5'd1, 1'b0);
        #1;
        total++;
        if (Stall_o !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", Stall_o); end
        tick();
        // bubble in EX, load in MEM, add re-presented in ID
        total++;
        if ({ALU_Op_EX_o, ALU_Src_EX_o, Branch_EX_o, Jal_EX_o, Jalr_EX_o} !== 7'd0) begin
            bad++; $display("FAIL lu_bubble got=%b exp=0", {ALU_Op_EX_o, ALU_Src_EX_o, Branch_EX_o, Jal_EX_o, Jalr_EX_o});
        end
        total++;
        if (Stall_o !== 1'b0) begin bad++; $display("FAIL lu_stall_once got=%b exp=0", Stall_o); end
        total++;
        if ({Mem_Read_MEM_o, Rd_MEM_o} !== {1'b1, 5'd6}) begin bad++; $display("FAIL lu_mem got=%b_%0d exp=1_6", Mem_Read_MEM_o, Rd_MEM_o); end
        tick();
        drive(7'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        total++;
        if ({Mem_to_Reg_WB_o, Rd_WB_o} !== {1'b1, 5'd6}) begin bad++; $display("FAIL lu_wb got=%b_%0d exp=1_6", Mem_to_Reg_WB_o, Rd_WB_o); end
        tick();
        total++;
        if ({Mem_Read_MEM_o, Rd_MEM_o} !== {1'b0, 5'd7}) begin bad++; $display("FAIL lu_add_mem got=%b_%0d exp=0_7", Mem_Read_MEM_o, Rd_MEM_o); end
        tick();
    endtask

    task automatic test_x0();
        drive(LD_OP, 5'd0, 5'd1, 5'd0, 1'b0);
        tick();
        drive(R_OP, 5'd3, 5'd0, 5'd0, 1'b0);
        #1;
        total++;
        if (Stall_o !== 1'b0) begin bad++; $display("FAIL x0_stall got=%b exp=0", Stall_o); end
        tick();
    endtask

    task automatic test_flush();
        drive(B_OP, 5'd0, 5'd1, 5'd2, 1'b0);
        tick();
        total++;
        if ({Branch_EX_o, ALU_Op_EX_o} !== 4'b1011) begin bad++; $display("FAIL beq_ex got=%b exp=1011", {Branch_EX_o, ALU_Op_EX_o}); end
        drive(LD_OP, 5'd4, 5'd1, 5'd0, 1'b0);
        tick();
        // load x4 in EX, its user in ID, and a redirect arrives
        drive(R_OP, 5'd8, 5'd4, 5'd4, 1'b1);
        #1;
        total++;
        if ({Flush_IF_ID_o, Stall_o} !== 2'b10) begin bad++; $display("FAIL flush_hz got=%b exp=10", {Flush_IF_ID_o, Stall_o}); end
        tick();
        drive(7'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        total++;
        if ({ALU_Op_EX_o, ALU_Src_EX_o, Mem_Read_MEM_o, Rd_MEM_o} !== {4'b0000, 1'b1, 5'd4}) begin
            bad++; $display("FAIL flush_stage got=%b_%b_%0d exp=0000_1_4", {ALU_Op_EX_o, ALU_Src_EX_o}, Mem_Read_MEM_o, Rd_MEM_o);
        end
        tick();
        total++;
        if (Rd_MEM_o !== 5'd0) begin bad++; $display("FAIL flush_killed got=%0d exp=0", Rd_MEM_o); end
    endtask

    task automatic test_jalr();
        drive(JALR_OP, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        drive(7'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        total++;
        if ({Jalr_EX_o, Jal_EX_o, ALU_Src_EX_o, ALU_Op_EX_o} !== 6'b101111) begin
            bad++; $display("FAIL jalr_ex got=%b exp=101111", {Jalr_EX_o, Jal_EX_o, ALU_Src_EX_o, ALU_Op_EX_o});
        end
        tick();
        tick();
        total++;
        if ({Jal_WB_o, Reg_Write_WB_o, Rd_WB_o} !== {2'b11, 5'd1}) begin
            bad++; $display("FAIL jalr_wb got=%b_%0d exp=11_1", {Jal_WB_o, Reg_Write_WB_o}, Rd_WB_o);
        end
    endtask

    task automatic test_undef();
        drive(UNDEF_OP, 5'd9, 5'd1, 5'd2, 1'b0);
        tick();
        drive(7'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (all_regs !== 22'd0) begin bad++; $display("FAIL undef_stage%0d got=%h exp=0", i, all_regs); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        drive(LD_OP, 5'd6, 5'd0, 5'd0, 1'b0);
        tick();
        drive(R_OP, 5'd7, 5'd6, 5'd0, 1'b0);
        #1;
        total++;
        if ({Stall_o, ALU_Src_EX_o} !== 2'b11) begin bad++; $display("FAIL rstmid_pre got=%b exp=11", {Stall_o, ALU_Src_EX_o}); end
        reset = 1'b1;
        #1;
        total++;
        if ({Stall_o, all_regs} !== 23'd0) begin bad++; $display("FAIL rstmid_async got=%h exp=0", {Stall_o, all_regs}); end
        drive(7'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        reset = 1'b0;
        tick();
    endtask

`ifdef CTRL_PERF_CNT_EN
    task automatic test_perf();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(LD_OP, 5'd2, 5'd0, 5'd0, 1'b0);
            tick();
            drive(R_OP, 5'd3, 5'd2, 5'd0, 1'b0);
            tick();
            tick();
        end
        drive(7'h00, 5'd0, 5'd0, 5'd0, 1'b1);
        tick();
        tick();
        drive(7'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        total++;
        if ({Stall_Cnt_o, Flush_Cnt_o} !== {16'd3, 16'd2}) begin
            bad++; $display("FAIL perf_cnt got=%0d/%0d exp=3/2", Stall_Cnt_o, Flush_Cnt_o);
        end
    endtask
`endif

    task automatic test_random();
        slot_t ex_s, mem_s, wb_s, id_s, bub;
        logic [4:0] s1, s2;
        logic rdr, exp_stall, hold;
        int k, ce, cm, cw, ci;
        logic [8:0] exp_ex;
        logic [6:0] exp_mem;
        logic [7:0] exp_wb;
        bub.op = 7'h00; bub.rd = 5'd0;
        ex_s = bub; mem_s = bub; wb_s = bub; id_s = bub;
        s1 = 5'd0; s2 = 5'd0; hold = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!hold) begin
                k = $urandom_range(0, 9);
                id_s.op = (k < 8) ? tbl[k] : ((k == 8) ? UNDEF_OP : 7'b0001111);
                id_s.rd = 5'($urandom_range(0, 3));
                s1 = 5'($urandom_range(0, 3));
                s2 = 5'($urandom_range(0, 3));
            end
            rdr = ($urandom_range(0, 5) == 0);
            drive(id_s.op, id_s.rd, s1, s2, rdr);
            #2;
            ce = code_of(ex_s.op); cm = code_of(mem_s.op); cw = code_of(wb_s.op); ci = code_of(id_s.op);
            exp_stall = (ce == 5) && (ex_s.rd != 0) && ((ex_s.rd == s1) || (ex_s.rd == s2)) &&
                        (ci != 2) && (ci != 6) && !rdr;
            exp_ex  = {(ce >= 0) ? 3'(ce) : 3'd0, (ce >= 0) && (ce != 0) && (ce != 3),
                       ce == 3, ce == 6, ce == 7, exp_stall, rdr};
            exp_mem = {cm == 5, cm == 4, (cm >= 0) ? mem_s.rd : 5'd0};
            exp_wb  = {(cw >= 0) && (cw != 3) && (cw != 4), cw == 5, cw >= 6, (cw >= 0) ? wb_s.rd : 5'd0};
            total++;
            if ({ALU_Op_EX_o, ALU_Src_EX_o, Branch_EX_o, Jal_EX_o, Jalr_EX_o, Stall_o, Flush_IF_ID_o} !== exp_ex) begin
                bad++; $display("FAIL rnd_ex cyc=%0d got=%b exp=%b", cyc,
                    {ALU_Op_EX_o, ALU_Src_EX_o, Branch_EX_o, Jal_EX_o, Jalr_EX_o, Stall_o, Flush_IF_ID_o}, exp_ex);
            end
            total++;
            if ({Mem_Read_MEM_o, Mem_Write_MEM_o, Rd_MEM_o} !== exp_mem) begin
                bad++; $display("FAIL rnd_mem cyc=%0d got=%b exp=%b", cyc, {Mem_Read_MEM_o, Mem_Write_MEM_o, Rd_MEM_o}, exp_mem);
            end
            total++;
            if ({Reg_Write_WB_o, Mem_to_Reg_WB_o, Jal_WB_o, Rd_WB_o} !== exp_wb) begin
                bad++; $display("FAIL rnd_wb cyc=%0d got=%b exp=%b", cyc, {Reg_Write_WB_o, Mem_to_Reg_WB_o, Jal_WB_o, Rd_WB_o}, exp_wb);
            end
            @(posedge clk);
            wb_s  = mem_s;
            mem_s = ex_s;
            ex_s  = (exp_stall || rdr) ? bub : id_s;
            hold  = exp_stall;
            #1;
        end
    endtask

    initial begin
        tbl[0] = R_OP;  tbl[1] = 7'b0010011; tbl[2] = LUI_OP; tbl[3] = B_OP;
        tbl[4] = 7'b0100011; tbl[5] = LD_OP; tbl[6] = JAL_OP; tbl[7] = JALR_OP;
        test_reset();
        test_rtype();
        test_load_use();
        test_x0();
        test_flush();
        test_jalr();
        test_undef();
        test_reset_mid();
`ifdef CTRL_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
